// File: rtl/mem_access_unit.sv
// Purpose: data-memory access unit (MEM stage). It owns the word array and
//          the per-word dirty bitmap, performs sized loads and stores with
//          wait states, and serves debug reads between pipeline accesses.
// Latency: a request sampled in cycle T commits at the end of T+WAIT_STATES.
//          A misaligned access or a non-memory instruction takes one cycle.
//          A debug read returns one cycle after it is accepted.
// Backpressure: o_stall holds the upstream stages for WAIT_STATES cycles per
//          aligned access. Debug reads never stall the pipeline.
// Ports:   i_clock/i_reset (synchronous, active-high), i_enable (freeze);
//          pipeline request i_mem_read/i_mem_write/i_size/i_unsigned/i_addr/
//          i_wdata/i_wb_ctrl; debug i_dbg_req/i_dbg_addr/i_dbg_clear_dirty;
//          results o_stall, o_rdata, o_wb_ctrl, o_misaligned, o_dbg_valid,
//          o_dbg_data, o_dbg_dirty, o_dirty_count.
module mem_access_unit #(
    parameter int NB_DATA     = 32,
    parameter int DEPTH       = 128,
    parameter int NB_ADDR     = 32,
    parameter int WAIT_STATES = 2,
    parameter int NB_WB_CTRL  = 3,
    localparam int NB_IDX     = $clog2(DEPTH)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [NB_ADDR-1:0]    i_addr,
    input  logic [NB_DATA-1:0]    i_wdata,
    input  logic [NB_WB_CTRL-1:0] i_wb_ctrl,
    input  logic                  i_dbg_req,
    input  logic [NB_IDX-1:0]     i_dbg_addr,
    input  logic                  i_dbg_clear_dirty,
    output logic                  o_stall,
    output logic [NB_DATA-1:0]    o_rdata,
    output logic [NB_WB_CTRL-1:0] o_wb_ctrl,
    output logic                  o_misaligned,
    output logic                  o_dbg_valid,
    output logic [NB_DATA-1:0]    o_dbg_data,
    output logic                  o_dbg_dirty,
    output logic [NB_IDX:0]       o_dirty_count
);

    localparam int NB_CNT = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DBG = 2'd2} state_t;

    state_t                  state, state_nxt;
    logic [NB_CNT-1:0]       wait_cnt;

    logic [NB_DATA-1:0]      mem [DEPTH];
    logic [DEPTH-1:0]        dirty, dirty_base, dirty_nxt;
    logic [NB_IDX:0]         dirty_cnt_base, dirty_cnt_nxt;

    // Request captured at the start of a multi-cycle access.
    logic                    lat_read, lat_write, lat_unsigned;
    logic [1:0]              lat_size;
    logic [NB_IDX+1:0]       lat_addr;
    logic [NB_DATA-1:0]      lat_wdata;
    logic [NB_WB_CTRL-1:0]   lat_wb_ctrl;

    // Access currently being served: latched copy while BUSY, live inputs otherwise.
    logic                    a_read_only, a_write, a_unsigned;
    logic [1:0]              a_size;
    logic [NB_IDX+1:0]       a_addr;
    logic [NB_DATA-1:0]      a_wdata;
    logic [NB_WB_CTRL-1:0]   a_wb_ctrl;
    logic [NB_IDX-1:0]       a_idx;

    logic [NB_DATA-1:0]      cur_word, store_word, load_data;
    logic [7:0]              lane_byte;
    logic [15:0]             lane_half;

    logic req, open_slot, new_req, new_mis, start_wait, busy_done, commit, commit_write;

    // Address bits above the word index do not select anything.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_addr[NB_ADDR-1:NB_IDX+2];

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = lane[0];
            default: is_misaligned = (lane != 2'b00);
        endcase
    endfunction

    assign req        = i_mem_read | i_mem_write;
    // A DBG cycle also accepts pipeline work: debug never stalls, so the
    // upstream stage may present a request while the debug read completes.
    assign open_slot  = (state == IDLE) || (state == DBG);
    assign new_req    = open_slot & req;
    assign new_mis    = new_req & is_misaligned(i_size, i_addr[1:0]);
    assign start_wait = new_req & ~new_mis & (WAIT_STATES != 0);
    assign busy_done  = (state == BUSY) && (wait_cnt == NB_CNT'(1));
    assign commit     = busy_done || (new_req && !new_mis && (WAIT_STATES == 0));
    assign commit_write = commit & a_write;

    always_comb begin
        if (state == BUSY) begin
            a_read_only = lat_read & ~lat_write;
            a_write     = lat_write;
            a_unsigned  = lat_unsigned;
            a_size      = lat_size;
            a_addr      = lat_addr;
            a_wdata     = lat_wdata;
            a_wb_ctrl   = lat_wb_ctrl;
        end else begin
            a_read_only = i_mem_read & ~i_mem_write;
            a_write     = i_mem_write;
            a_unsigned  = i_unsigned;
            a_size      = i_size;
            a_addr      = i_addr[NB_IDX+1:0];
            a_wdata     = i_wdata;
            a_wb_ctrl   = i_wb_ctrl;
        end
    end

    assign a_idx    = a_addr[NB_IDX+1:2];
    assign cur_word = mem[a_idx];

    // Little-endian lanes; sub-word accesses only touch bits 31:0.
    always_comb begin
        store_word = cur_word;
        load_data  = '0;
        lane_byte  = cur_word[{a_addr[1:0], 3'b000} +: 8];
        lane_half  = cur_word[{a_addr[1], 4'b0000} +: 16];
        case (a_size)
            2'b00: begin
                store_word[{a_addr[1:0], 3'b000} +: 8] = a_wdata[7:0];
                load_data = {{(NB_DATA-8){~a_unsigned & lane_byte[7]}}, lane_byte};
            end
            2'b01: begin
                store_word[{a_addr[1], 4'b0000} +: 16] = a_wdata[15:0];
                load_data = {{(NB_DATA-16){~a_unsigned & lane_half[15]}}, lane_half};
            end
            default: begin
                store_word = a_wdata;
                load_data  = cur_word;
            end
        endcase
    end

    // A clear lands before a same-cycle write sets its bit.
    always_comb begin
        dirty_base     = i_dbg_clear_dirty ? '0 : dirty;
        dirty_cnt_base = i_dbg_clear_dirty ? '0 : o_dirty_count;
        dirty_nxt      = dirty_base;
        dirty_cnt_nxt  = dirty_cnt_base;
        if (commit_write && !dirty_base[a_idx]) begin
            dirty_nxt[a_idx] = 1'b1;
            dirty_cnt_nxt    = dirty_cnt_base + (NB_IDX+1)'(1);
        end
    end

    // FSM: state register
    always_ff @(posedge i_clock) begin
        if (i_reset)       state <= IDLE;
        else if (i_enable) state <= state_nxt;
    end

    // FSM: next state; the pipeline wins a tie with a debug request
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_wait)              state_nxt = BUSY;
                else if (i_dbg_req && !req)  state_nxt = DBG;
            end
            DBG:     state_nxt = start_wait ? BUSY : IDLE;
            BUSY:    if (busy_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_stall = start_wait | ((state == BUSY) && !busy_done);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wait_cnt      <= '0;
            lat_read      <= 1'b0;
            lat_write     <= 1'b0;
            lat_unsigned  <= 1'b0;
            lat_size      <= '0;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            lat_wb_ctrl   <= '0;
            o_rdata       <= '0;
            o_wb_ctrl     <= '0;
            o_misaligned  <= 1'b0;
            o_dbg_valid   <= 1'b0;
            o_dbg_data    <= '0;
            o_dbg_dirty   <= 1'b0;
            dirty         <= '0;
            o_dirty_count <= '0;
        end else if (i_enable) begin
            if (start_wait) begin
                lat_read     <= i_mem_read;
                lat_write    <= i_mem_write;
                lat_unsigned <= i_unsigned;
                lat_size     <= i_size;
                lat_addr     <= i_addr[NB_IDX+1:0];
                lat_wdata    <= i_wdata;
                lat_wb_ctrl  <= i_wb_ctrl;
                wait_cnt     <= NB_CNT'(WAIT_STATES);
            end else if (state == BUSY) begin
                wait_cnt     <= wait_cnt - NB_CNT'(1);
            end

            if (commit) begin
                o_rdata      <= a_read_only ? load_data : '0;
                o_wb_ctrl    <= a_wb_ctrl;
                o_misaligned <= 1'b0;
            end else if (new_mis) begin
                o_rdata      <= '0;
                o_wb_ctrl    <= i_wb_ctrl;
                o_misaligned <= 1'b1;
            end else if (open_slot && !req) begin
                o_rdata      <= '0;
                o_wb_ctrl    <= i_wb_ctrl;
                o_misaligned <= 1'b0;
            end else begin
                // Bubble while waiting so WB never retires an instruction twice.
                o_rdata      <= '0;
                o_wb_ctrl    <= '0;
                o_misaligned <= 1'b0;
            end

            o_dbg_valid <= (state == DBG);
            if (state == DBG) begin
                o_dbg_data  <= mem[i_dbg_addr];
                o_dbg_dirty <= dirty[i_dbg_addr];
            end

            dirty         <= dirty_nxt;
            o_dirty_count <= dirty_cnt_nxt;
        end
    end

    // Contents survive reset; a write in flight at reset is dropped.
    always_ff @(posedge i_clock) begin
        if (!i_reset && i_enable && commit_write)
            mem[a_idx] <= store_word;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: self-checking bench for mem_access_unit (defaults: 32-bit, 128 words, 2 wait states).
// Latency: expectations follow the transaction timing (stall T..T+WS-1, result after T+WS).
// Backpressure: the driver holds each request until its commit cycle.
module tb_mem_access_unit;

    localparam int WS = 2;

    logic        i_clock = 1'b0;
    logic        i_reset, i_enable, i_mem_read, i_mem_write, i_unsigned;
    logic [1:0]  i_size;
    logic [31:0] i_addr, i_wdata;
    logic [2:0]  i_wb_ctrl;
    logic        i_dbg_req, i_dbg_clear_dirty;
    logic [6:0]  i_dbg_addr;
    logic        o_stall, o_misaligned, o_dbg_valid, o_dbg_dirty;
    logic [31:0] o_rdata, o_dbg_data;
    logic [2:0]  o_wb_ctrl;
    logic [7:0]  o_dirty_count;

    mem_access_unit #(
        .NB_DATA(32), .DEPTH(128), .NB_ADDR(32), .WAIT_STATES(WS), .NB_WB_CTRL(3)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_size(i_size),
        .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_wb_ctrl(i_wb_ctrl), .i_dbg_req(i_dbg_req), .i_dbg_addr(i_dbg_addr),
        .i_dbg_clear_dirty(i_dbg_clear_dirty), .o_stall(o_stall), .o_rdata(o_rdata),
        .o_wb_ctrl(o_wb_ctrl), .o_misaligned(o_misaligned), .o_dbg_valid(o_dbg_valid),
        .o_dbg_data(o_dbg_data), .o_dbg_dirty(o_dbg_dirty), .o_dirty_count(o_dirty_count)
    );

    always #5 i_clock = ~i_clock;

    // Reference model: memory words, dirty flags and count.
    bit [31:0] mmem [128];
    bit        mdirty [128];
    int        mcount = 0;

    logic        exp_stall = 1'b0, exp_mis = 1'b0, exp_dv = 1'b0, exp_ddirty = 1'b0;
    logic [31:0] exp_rdata = '0, exp_dd = '0;
    logic [2:0]  exp_wb = '0;
    bit          chk_en = 1'b0;
    int          n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clock) begin
        if (chk_en) begin
            check("stall",       32'(o_stall),       32'(exp_stall));
            check("rdata",       o_rdata,            exp_rdata);
            check("wb_ctrl",     32'(o_wb_ctrl),     32'(exp_wb));
            check("misaligned",  32'(o_misaligned),  32'(exp_mis));
            check("dbg_valid",   32'(o_dbg_valid),   32'(exp_dv));
            check("dirty_count", 32'(o_dirty_count), 32'(mcount));
            if (exp_dv) begin
                check("dbg_data",  o_dbg_data,        exp_dd);
                check("dbg_dirty", 32'(o_dbg_dirty),  32'(exp_ddirty));
            end
        end
    end

    function automatic bit [31:0] model_load(bit [31:0] w, bit [1:0] sz, bit uns, bit [1:0] lane);
        bit [31:0] v;
        case (sz)
            2'd0: begin
                v = (w >> (8 * lane)) & 32'hFF;
                if (!uns && v[7]) v = v | 32'hFFFFFF00;
            end
            2'd1: begin
                v = (w >> (16 * lane[1])) & 32'hFFFF;
                if (!uns && v[15]) v = v | 32'hFFFF0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic bit [31:0] model_store(bit [31:0] w, bit [1:0] sz, bit [1:0] lane, bit [31:0] d);
        bit [31:0] mask;
        int sh;
        case (sz)
            2'd0: begin sh = 8 * lane;     mask = 32'hFF << sh; end
            2'd1: begin sh = 16 * lane[1]; mask = 32'hFFFF << sh; end
            default: begin sh = 0;         mask = 32'hFFFFFFFF; end
        endcase
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic idle_step(input bit [2:0] wb);
        i_wb_ctrl = wb;
        exp_stall = 1'b0;
        step();
        exp_rdata = '0; exp_wb = wb; exp_mis = 1'b0; exp_dv = 1'b0;
    endtask

    // One pipeline access; clr raises the dirty clear in the commit cycle,
    // frz drops enable for that many cycles after the first wait cycle.
    task automatic mem_op(input bit rd, input bit wr, input bit [1:0] sz, input bit uns,
                          input bit [31:0] addr, input bit [31:0] wdat, input bit [2:0] wb,
                          input bit clr, input int frz);
        int idx;
        bit mis;
        bit [31:0] ld;
        idx = int'(addr[8:2]);
        mis = (sz == 2'd1 && addr[0]) || (sz[1] && addr[1:0] != 2'd0);
        ld  = model_load(mmem[idx], sz, uns, addr[1:0]);
        i_mem_read = rd; i_mem_write = wr; i_size = sz; i_unsigned = uns;
        i_addr = addr; i_wdata = wdat; i_wb_ctrl = wb;
        if (mis) begin
            exp_stall = 1'b0;
            step();
            exp_rdata = '0; exp_wb = wb; exp_mis = 1'b1;
        end else begin
            exp_stall = (WS > 0);
            for (int k = 1; k <= WS; k++) begin
                step();
                exp_rdata = '0; exp_wb = '0; exp_mis = 1'b0;
                exp_stall = (k < WS);
                if (k == 1 && frz > 0) begin
                    i_enable = 1'b0;
                    repeat (frz) step();
                    i_enable = 1'b1;
                end
                if (k == WS && clr) i_dbg_clear_dirty = 1'b1;
            end
            step();
            i_dbg_clear_dirty = 1'b0;
            exp_stall = 1'b0; exp_mis = 1'b0; exp_wb = wb;
            exp_rdata = (rd && !wr) ? ld : 32'h0;
            if (wr) begin
                if (clr) begin
                    foreach (mdirty[i]) mdirty[i] = 1'b0;
                    mcount = 0;
                end
                mmem[idx] = model_store(mmem[idx], sz, addr[1:0], wdat);
                if (!mdirty[idx]) begin
                    mdirty[idx] = 1'b1;
                    mcount++;
                end
            end
        end
        i_mem_read = 1'b0; i_mem_write = 1'b0; i_wb_ctrl = '0;
    endtask

    // Debug request already raised and accepted this cycle; leaves the bench in the valid cycle.
    task automatic finish_dbg(input int idx);
        idle_step(3'd0);
        idle_step(3'd0);
        exp_dv = 1'b1; exp_dd = mmem[idx]; exp_ddirty = mdirty[idx];
        i_dbg_req = 1'b0;
    endtask

    task automatic dbg_read(input int idx);
        i_dbg_req = 1'b1;
        i_dbg_addr = 7'(idx);
        finish_dbg(idx);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; i_enable = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b0;
        i_size = '0; i_unsigned = 1'b0; i_addr = '0; i_wdata = '0; i_wb_ctrl = '0;
        i_dbg_req = 1'b0; i_dbg_addr = '0; i_dbg_clear_dirty = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        step();
        i_reset = 1'b0;
        idle_step(3'd0);

        // Non-memory pass-through
        idle_step(3'd5);
        check("passthru_wb_lit", 32'(o_wb_ctrl), 32'd5);
        idle_step(3'd0);

        // Word store then load
        mem_op(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 3'd1, 0, 0);
        check("count_after_store_lit", 32'(o_dirty_count), 32'd1);
        mem_op(1, 0, 2'd2, 0, 32'h10, 32'h0, 3'd2, 0, 0);
        check("ld_word_lit", o_rdata, 32'hDEADBEEF);

        // Byte store into a known word, sized loads
        mem_op(0, 1, 2'd2, 0, 32'h20, 32'h11223344, 3'd1, 0, 0);
        mem_op(0, 1, 2'd0, 0, 32'h21, 32'h00000080, 3'd1, 0, 0);
        mem_op(1, 0, 2'd0, 0, 32'h21, 32'h0, 3'd2, 0, 0);
        check("ld_byte_signed_lit", o_rdata, 32'hFFFFFF80);
        mem_op(1, 0, 2'd0, 1, 32'h21, 32'h0, 3'd2, 0, 0);
        check("ld_byte_unsigned_lit", o_rdata, 32'h00000080);
        mem_op(1, 0, 2'd1, 0, 32'h20, 32'h0, 3'd2, 0, 0);
        check("ld_half_signed_lit", o_rdata, 32'hFFFF8044);
        mem_op(1, 0, 2'd2, 0, 32'h20, 32'h0, 3'd2, 0, 0);
        check("ld_word8_lit", o_rdata, 32'h11228044);

        // Misaligned accesses
        mem_op(1, 0, 2'd1, 0, 32'h03, 32'h0, 3'd3, 0, 0);
        check("misaligned_lit", 32'(o_misaligned), 32'd1);
        idle_step(3'd0);
        mem_op(0, 1, 2'd2, 0, 32'h12, 32'hFFFFFFFF, 3'd1, 0, 0);
        idle_step(3'd0);
        check("mis_store_count_lit", 32'(o_dirty_count), 32'd2);
        mem_op(1, 0, 2'd2, 0, 32'h10, 32'h0, 3'd2, 0, 0);
        check("mis_store_no_write_lit", o_rdata, 32'hDEADBEEF);

        // Debug request tied with a pipeline load
        i_dbg_req = 1'b1; i_dbg_addr = 7'd8;
        mem_op(1, 0, 2'd2, 0, 32'h20, 32'h0, 3'd2, 0, 0);
        check("tie_load_first_lit", o_rdata, 32'h11228044);
        finish_dbg(8);
        check("tie_dbg_data_lit", o_dbg_data, 32'h11228044);
        check("tie_dbg_dirty_lit", 32'(o_dbg_dirty), 32'd1);
        idle_step(3'd0);

        // Enable freeze inside a wait
        mem_op(1, 0, 2'd2, 0, 32'h10, 32'h0, 3'd2, 0, 2);
        check("freeze_load_lit", o_rdata, 32'hDEADBEEF);

        // Dirty clear in the commit cycle of another write
        mem_op(0, 1, 2'd2, 0, 32'h14, 32'h00000055, 3'd1, 0, 0);
        mem_op(0, 1, 2'd2, 0, 32'h18, 32'h00000066, 3'd1, 1, 0);
        check("clear_count_lit", 32'(o_dirty_count), 32'd1);
        dbg_read(5);
        check("word5_clean_lit", 32'(o_dbg_dirty), 32'd0);
        idle_step(3'd0);
        dbg_read(6);
        check("word6_dirty_lit", 32'(o_dbg_dirty), 32'd1);
        idle_step(3'd0);

        // Reset during a store wait
        mem_op(0, 1, 2'd2, 0, 32'h24, 32'h12345678, 3'd1, 0, 0);
        i_mem_write = 1'b1; i_size = 2'd2; i_addr = 32'h24; i_wdata = 32'hAAAAAAAA; i_wb_ctrl = 3'd4;
        exp_stall = 1'b1;
        step();
        exp_rdata = '0; exp_wb = '0; exp_mis = 1'b0; exp_stall = 1'b1;
        i_reset = 1'b1; i_mem_write = 1'b0; i_wb_ctrl = '0;
        step();
        exp_stall = 1'b0; exp_dv = 1'b0;
        foreach (mdirty[i]) mdirty[i] = 1'b0;
        mcount = 0;
        check("reset_count_lit", 32'(o_dirty_count), 32'd0);
        i_reset = 1'b0;
        idle_step(3'd0);
        mem_op(1, 0, 2'd2, 0, 32'h24, 32'h0, 3'd2, 0, 0);
        check("reset_abort_lit", o_rdata, 32'h12345678);

        // Read and write together is a write
        mem_op(1, 1, 2'd2, 0, 32'h28, 32'hCAFEF00D, 3'd6, 0, 0);
        check("rw_rdata_lit", o_rdata, 32'h0);
        mem_op(1, 0, 2'd2, 0, 32'h28, 32'h0, 3'd2, 0, 0);
        check("rw_stored_lit", o_rdata, 32'hCAFEF00D);
        idle_step(3'd0);
        idle_step(3'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised successor of the pipeline MEM stage: a data-memory access unit with configurable data width, depth and wait-state latency. It owns the data memory array and its per-word dirty bitmap, handles sized signed/unsigned loads and stores, and stalls the pipeline while a multi-cycle access completes. It registers WB control and load data toward the MEM/WB boundary, and serves a debug read port between pipeline accesses.

## Interface
- NB_DATA, 32, data width; multiple of 8, at least 32.
- DEPTH, 128, words in the memory array; power of two.
- NB_ADDR, 32, byte-address width.
- WAIT_STATES, 2, extra cycles per memory access; 0 gives single-cycle access.
- NB_WB_CTRL, 3, width of the WB control bundle passed through.
- i_clock  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_enable  in  1  pipeline enable; low freezes FSM, counters and output registers.
- i_mem_read / i_mem_write  in  1 each  access request; both high is treated as a write.
- i_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- i_unsigned  in  1  zero-extend loads when high, sign-extend when low.
- i_addr  in  NB_ADDR  byte address; word index = i_addr[2 +: log2(DEPTH)].
- i_wdata  in  NB_DATA  store data, right-aligned.
- i_wb_ctrl  in  NB_WB_CTRL  WB control for the instruction.
- i_dbg_req  in  1  debug read request; held high until o_dbg_valid.
- i_dbg_addr  in  log2(DEPTH)  debug word index.
- i_dbg_clear_dirty  in  1  clear the entire dirty bitmap.
- o_stall  out  1  combinational; upstream stages hold while high.
- o_rdata  out  NB_DATA  registered, extended load data.
- o_wb_ctrl  out  NB_WB_CTRL  registered WB control.
- o_misaligned  out  1  registered; one-cycle flag on a suppressed access.
- o_dbg_valid  out  1  one-cycle pulse; o_dbg_data and o_dbg_dirty are valid.
- o_dbg_data  out  NB_DATA  raw memory word.
- o_dbg_dirty  out  1  dirty bit of the debug word.
- o_dirty_count  out  log2(DEPTH)+1  number of dirty words.

## Operation
- FSM states are IDLE, BUSY and DBG. In IDLE with i_enable high, a request (read or write) is latched together with i_wb_ctrl. Inputs are ignored until the access completes.
- With WAIT_STATES=0 the access commits in the request cycle. Otherwise IDLE→BUSY, a counter is loaded with WAIT_STATES, and the counter decrements each enabled cycle. The access commits in the BUSY cycle where the count reaches 1, then the FSM returns to IDLE.
- Store lanes are little-endian:
  - byte writes lane addr[1:0];
  - half writes lane addr[1];
  - word writes the full word.
  - Other bytes are preserved. Bytes above bit 31 are written only by word stores.
- Loads extract the same lane, then sign- or zero-extend to NB_DATA.
- Misaligned accesses are a half with addr[0]=1 or a word with addr[1:0]≠0. These complete in one cycle with no write and o_rdata=0, o_misaligned=1, and no stall.
- Any completed write sets that word's dirty bit. o_dirty_count increments only on a 0→1 transition of a bit.
- i_dbg_clear_dirty clears all dirty bits and zeroes the count in one cycle. If a write commits in the same cycle, the clear applies first and the write's bit is then set, so count=1.
- Non-memory instructions (no read or write) pass i_wb_ctrl to o_wb_ctrl in one cycle, with o_rdata=0.
- Debug requests are accepted only in IDLE with no pipeline request that cycle; the pipeline wins ties. Acceptance moves the FSM to DBG. o_dbg_valid is pulsed on the next edge and the FSM returns to IDLE. Debug reads never assert o_stall.
- Reset affects registers only:
  - FSM→IDLE, counter 0, dirty bitmap cleared;
  - all outputs 0, including o_dirty_count;
  - memory contents unchanged.
  - An in-flight write is aborted without committing.

## Timing
- A request sampled in cycle T completes at the end of T+WAIT_STATES. o_rdata, o_wb_ctrl and o_misaligned update at the edge ending T+WAIT_STATES.
- o_stall is high in cycles T..T+WAIT_STATES−1 (WAIT_STATES cycles) and low in the commit cycle.
- Back-to-back requests: a new request can be sampled in the cycle after commit.
- When i_enable is low, no state changes at all and o_stall holds its value. When enable returns, operation resumes exactly where it stopped.
- Debug latency is one cycle from acceptance.

## Test plan
- WAIT_STATES=2: store word 0xDEADBEEF to addr 0x10, then load word from 0x10. Required: o_stall high for 2 cycles per access, o_rdata=0xDEADBEEF 3 cycles after the load is sampled, o_dirty_count=1.
- Store byte 0x80 to addr 0x21, then load byte signed and unsigned from 0x21. Required: 0xFFFFFF80 and 0x00000080; the other bytes of word 8 are unchanged.
- Load half from addr 0x03. Required: o_misaligned=1 for one cycle, o_rdata=0, no stall, memory and dirty bitmap unchanged.
- Debug request raised together with a pipeline load. Required: the load completes first; o_dbg_valid pulses one cycle after the FSM returns to IDLE, with the correct data and dirty bit.
- Write word 5, then assert i_dbg_clear_dirty in the commit cycle of a write to word 6. Required: o_dirty_count=1, word 5 clean, word 6 dirty.
- Assert i_reset in BUSY of a store to word 9. Required: word 9 keeps its old value, all outputs 0, FSM IDLE, and the next request is served normally.
